// File: rtl/ll_pkg.sv
// Shared types and sizing for the multi-queue linked list and its dequeue scheduler.
package ll_pkg;
  localparam int NUM_QUEUES  = 4;
  localparam int LL_DEPTH    = 64;
  localparam int DATA_WIDTH  = 6;
  localparam int RSP_LATENCY = 3;
  localparam int OUT_DEPTH   = 4;
  localparam int QID_W       = $clog2(NUM_QUEUES);
  localparam int CNT_W       = $clog2(LL_DEPTH + 1);
  localparam int FIFO_AW     = $clog2(OUT_DEPTH);
  localparam int FCNT_W      = $clog2(OUT_DEPTH + 1);

  typedef logic [QID_W-1:0] qid_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    qid_t                  qid;
  } ll_item_t;

  function automatic qid_t qid_inc(qid_t q);
    return (int'(q) == NUM_QUEUES - 1) ? qid_t'(0) : qid_t'(q + 1'b1);
  endfunction
endpackage

// File: rtl/ll_rr_arbiter.sv
// Combinational round-robin pick: first requesting queue at or after ptr_i.
module ll_rr_arbiter
  import ll_pkg::*;
(
  input  logic [NUM_QUEUES-1:0] req_i,
  input  logic [QID_W-1:0]      ptr_i,
  output logic                  gnt_vld_o,
  output logic [QID_W-1:0]      gnt_id_o
);
  int idx;

  // Scan farthest-first so the nearest requester to ptr_i overwrites the result.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_id_o  = '0;
    idx       = 0;
    for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NUM_QUEUES;
      if (req_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_id_o  = qid_t'(idx);
      end
    end
  end
endmodule

// File: rtl/ll_deq_scheduler.sv
// Dequeue engine for the multi-queue linked list: occupancy snoop, credit-gated
// round-robin issue, fixed-latency response capture into a fall-through FIFO.
module ll_deq_scheduler
  import ll_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        init_done,
  input  logic                        enq_vld_in,
  input  logic [QID_W-1:0]            enq_id_in,
  input  logic [NUM_QUEUES-1:0]       queue_en,
  output logic                        deq_vld_out,
  output logic [QID_W-1:0]            deq_id_out,
  input  logic [DATA_WIDTH-1:0]       deq_data_in,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [QID_W-1:0]            out_qid,
  output logic [NUM_QUEUES*CNT_W-1:0] queue_cnt,
  output logic                        ovf_err
);
  cnt_t                  cnt_q [NUM_QUEUES];
  cnt_t                  cnt_d [NUM_QUEUES];
  cnt_t                  total_q, total_d;
  qid_t                  rr_q, rr_d;
  logic                  ovf_q, ovf_d;
  logic [RSP_LATENCY:1]  vld_pipe_q;
  qid_t                  qid_pipe_q [RSP_LATENCY:1];
  ll_item_t              mem_q [OUT_DEPTH];
  logic [FIFO_AW-1:0]    wr_q, rd_q;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;

  logic [NUM_QUEUES-1:0] req;
  logic                  gnt_vld;
  qid_t                  gnt_id;
  logic                  credit_ok, issue, push, pop;
  logic                  enq_hit, iss_hit;
  int                    inflight, sum;

  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++)
      req[q] = init_done & queue_en[q] & (cnt_q[q] != '0);
  end

  ll_rr_arbiter u_arb (
    .req_i     (req),
    .ptr_i     (rr_q),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  assign push = vld_pipe_q[RSP_LATENCY];
  assign pop  = out_vld & out_rdy;

  // Every in-flight request already owns a FIFO slot; a pop this cycle frees one.
  always_comb begin
    inflight = 0;
    for (int s = 1; s <= RSP_LATENCY; s++)
      inflight += int'(vld_pipe_q[s]);
    credit_ok = (int'(fcnt_q) + inflight - int'(pop)) < OUT_DEPTH;
    issue     = gnt_vld & credit_ok;
  end

  assign deq_vld_out = issue;
  assign deq_id_out  = gnt_id;

  always_comb begin
    ovf_d   = ovf_q;
    sum     = 0;
    enq_hit = 1'b0;
    iss_hit = 1'b0;
    rr_d    = issue ? qid_inc(gnt_id) : rr_q;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      cnt_d[q] = cnt_q[q];
      enq_hit  = enq_vld_in && (enq_id_in == qid_t'(q));
      iss_hit  = issue && (gnt_id == qid_t'(q));
      // A full list cannot have accepted the entry, so it is not counted.
      if (enq_hit && (int'(total_q) == LL_DEPTH)) begin
        ovf_d   = 1'b1;
        enq_hit = 1'b0;
      end
      if (enq_hit && !iss_hit)
        cnt_d[q] = cnt_q[q] + CNT_W'(1);
      else if (iss_hit && !enq_hit)
        cnt_d[q] = cnt_q[q] - CNT_W'(1);
      sum += int'(cnt_d[q]);
    end
    total_d = CNT_W'(sum);
  end

  always_comb begin
    fcnt_d = fcnt_q;
    if (push && !pop)
      fcnt_d = fcnt_q + FCNT_W'(1);
    else if (pop && !push)
      fcnt_d = fcnt_q - FCNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int q = 0; q < NUM_QUEUES; q++) cnt_q[q] <= '0;
      for (int s = 1; s <= RSP_LATENCY; s++) qid_pipe_q[s] <= '0;
      total_q    <= '0;
      rr_q       <= '0;
      ovf_q      <= 1'b0;
      vld_pipe_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      fcnt_q     <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) cnt_q[q] <= cnt_d[q];
      total_q <= total_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
      vld_pipe_q[1] <= issue;
      qid_pipe_q[1] <= gnt_id;
      for (int s = 2; s <= RSP_LATENCY; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        qid_pipe_q[s] <= qid_pipe_q[s-1];
      end
      if (push) wr_q <= (int'(wr_q) == OUT_DEPTH - 1) ? '0 : wr_q + FIFO_AW'(1);
      if (pop)  rd_q <= (int'(rd_q) == OUT_DEPTH - 1) ? '0 : rd_q + FIFO_AW'(1);
      fcnt_q <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= '{data: deq_data_in, qid: qid_pipe_q[RSP_LATENCY]};
  end

  assign out_vld  = (fcnt_q != '0);
  assign out_data = out_vld ? mem_q[rd_q].data : '0;
  assign out_qid  = out_vld ? mem_q[rd_q].qid  : '0;
  assign ovf_err  = ovf_q;

  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++)
      queue_cnt[q*CNT_W +: CNT_W] = cnt_q[q];
  end
endmodule

// File: tb/tb_ll_deq_scheduler.sv
// Directed bench: linked-list response model, scoreboard fed at issue time,
// monitor checking every output handshake.
module tb_ll_deq_scheduler;
  import ll_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        init_done = 1'b0;
  logic                        enq_vld_in = 1'b0;
  logic [QID_W-1:0]            enq_id_in = '0;
  logic [NUM_QUEUES-1:0]       queue_en = '0;
  logic                        deq_vld_out;
  logic [QID_W-1:0]            deq_id_out;
  logic [DATA_WIDTH-1:0]       deq_data_in;
  logic                        out_vld;
  logic                        out_rdy = 1'b0;
  logic [DATA_WIDTH-1:0]       out_data;
  logic [QID_W-1:0]            out_qid;
  logic [NUM_QUEUES*CNT_W-1:0] queue_cnt;
  logic                        ovf_err;

  ll_deq_scheduler dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .enq_vld_in(enq_vld_in), .enq_id_in(enq_id_in), .queue_en(queue_en),
    .deq_vld_out(deq_vld_out), .deq_id_out(deq_id_out), .deq_data_in(deq_data_in),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_qid(out_qid),
    .queue_cnt(queue_cnt), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, n_outvld = 0;
  int issue_log[$], issue_cyc[$], out_log[$], out_cyc[$], pop_cyc[$];
  ll_item_t sb[$];
  ll_item_t exp_item;
  logic [DATA_WIDTH-1:0] mq [NUM_QUEUES][$];
  logic [DATA_WIDTH-1:0] s0 = '0, d1 = '0, d2 = '0, d3 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Linked-list read model: data for a request sampled at edge N is valid before edge N+RSP_LATENCY.
  always @(posedge clk) begin
    d1 <= s0;
    d2 <= d1;
    d3 <= d2;
  end
  assign deq_data_in = d3;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qcnt(input int q);
    return int'(queue_cnt[q*CNT_W +: CNT_W]);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (deq_vld_out) begin
        issue_log.push_back(int'(deq_id_out));
        issue_cyc.push_back(cyc);
        if (mq[deq_id_out].size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL deq_empty: issue to q%0d holding 0 entries, expected no issue", deq_id_out);
          s0 = '0;
        end else begin
          s0 = mq[deq_id_out].pop_front();
          sb.push_back('{data: s0, qid: deq_id_out});
        end
      end else begin
        s0 = '0;
      end
      if (out_vld) begin
        n_outvld++;
        out_cyc.push_back(cyc);
        if (out_rdy) begin
          pop_cyc.push_back(cyc);
          out_log.push_back(int'(out_data));
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_out: data %0d qid %0d, expected no output", out_data, out_qid);
          end else begin
            exp_item = sb.pop_front();
            check("out_data", int'(out_data), int'(exp_item.data));
            check("out_qid", int'(out_qid), int'(exp_item.qid));
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    sb.delete();
    for (int q = 0; q < NUM_QUEUES; q++) mq[q].delete();
    issue_log.delete(); issue_cyc.delete();
    out_log.delete(); out_cyc.delete(); pop_cyc.delete();
    n_outvld = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enq_vld_in = 1'b0;
    clear_model();
    tick(2);
    reset = 1'b0;
    n_outvld = 0;
  endtask

  task automatic enq(input int q, input int d);
    enq_vld_in = 1'b1;
    enq_id_in  = qid_t'(q);
    mq[q].push_back(DATA_WIDTH'(d));
    tick();
    enq_vld_in = 1'b0;
  endtask

  task automatic wait_issues(input int n, input int budget);
    for (int i = 0; i < budget && issue_log.size() < n; i++) tick();
    check("wait_issues", issue_log.size(), n);
  endtask

  int cnt1, d;

  initial begin
    // 1: idle after reset
    tick();
    check("rst_out_vld", int'(out_vld), 0);
    check("rst_deq_vld", int'(deq_vld_out), 0);
    check("rst_queue_cnt", int'(queue_cnt), 0);
    check("rst_ovf", int'(ovf_err), 0);
    do_reset();
    init_done = 1'b1; queue_en = '1; out_rdy = 1'b1;
    tick(10);
    check("idle_issues", issue_log.size(), 0);
    check("idle_out_vld", n_outvld, 0);
    check("idle_cnt", int'(queue_cnt), 0);

    // 2: five items through q0
    do_reset();
    for (int i = 1; i <= 5; i++) enq(0, i);
    tick(15);
    check("t2_issues", issue_log.size(), 5);
    if (issue_log.size() == 5) begin
      for (int i = 0; i < 5; i++) check("t2_issue_id", issue_log[i], 0);
      check("t2_back_to_back", issue_cyc[4] - issue_cyc[0], 4);
    end
    if (issue_cyc.size() > 0 && out_cyc.size() > 0)
      check("t2_latency", out_cyc[0] - issue_cyc[0], RSP_LATENCY + 1);
    check("t2_outs", out_log.size(), 5);
    if (out_log.size() == 5)
      for (int i = 0; i < 5; i++) check("t2_out_data", out_log[i], i + 1);
    check("t2_cnt0", qcnt(0), 0);
    check("t2_sb_empty", sb.size(), 0);

    // 3: round robin across all queues
    do_reset();
    queue_en = '0;
    for (int i = 0; i < 3; i++)
      for (int q = 0; q < NUM_QUEUES; q++) enq(q, q * 8 + i);
    queue_en = '1;
    tick(25);
    check("t3_issues", issue_log.size(), 12);
    if (issue_log.size() == 12)
      for (int i = 0; i < 12; i++) check("t3_rr_order", issue_log[i], i % NUM_QUEUES);
    check("t3_outs", out_log.size(), 12);
    check("t3_sb_empty", sb.size(), 0);

    // 4: credit stall with consumer blocked
    do_reset();
    out_rdy = 1'b0;
    for (int i = 0; i < 10; i++) enq(1, 32 + i);
    tick(20);
    check("t4_stall_issues", issue_log.size(), OUT_DEPTH);
    check("t4_out_vld", int'(out_vld), 1);
    check("t4_cnt1", qcnt(1), 10 - OUT_DEPTH);
    out_rdy = 1'b1;
    tick(30);
    check("t4_issues", issue_log.size(), 10);
    check("t4_outs", out_log.size(), 10);
    if (out_log.size() == 10)
      for (int i = 0; i < 10; i++) check("t4_out_data", out_log[i], 32 + i);
    if (issue_cyc.size() > OUT_DEPTH && pop_cyc.size() > 0) begin
      d = issue_cyc[OUT_DEPTH] - pop_cyc[0];
      check("t4_resume", int'(d == 0 || d == 1), 1);
    end
    check("t4_cnt1_end", qcnt(1), 0);

    // 5: masked queue
    do_reset();
    queue_en = '0;
    for (int i = 0; i < 2; i++)
      for (int q = 0; q < NUM_QUEUES; q++) enq(q, 48 + q * 2 + i);
    queue_en = 4'b1101;
    tick(20);
    cnt1 = 0;
    foreach (issue_log[i]) if (issue_log[i] == 1) cnt1++;
    check("t5_issues", issue_log.size(), 6);
    check("t5_no_q1", cnt1, 0);
    check("t5_cnt1", qcnt(1), 2);
    queue_en = '1;
    tick(15);
    check("t5_issues_all", issue_log.size(), 8);
    if (issue_log.size() == 8) begin
      check("t5_q1_a", issue_log[6], 1);
      check("t5_q1_b", issue_log[7], 1);
    end
    check("t5_cnt1_end", qcnt(1), 0);
    check("t5_outs", out_log.size(), 8);

    // 6: reset with responses in flight, then overflow
    do_reset();
    enq(2, 7);
    enq(2, 8);
    wait_issues(2, 10);
    reset = 1'b1;
    clear_model();
    tick(2);
    reset = 1'b0;
    n_outvld = 0;
    tick(10);
    check("t6_no_out", n_outvld, 0);
    check("t6_no_issue", issue_log.size(), 0);
    check("t6_cnt", int'(queue_cnt), 0);
    queue_en = '0;
    for (int i = 0; i < LL_DEPTH; i++) enq(i % NUM_QUEUES, 0);
    tick();
    check("t6_ovf_before", int'(ovf_err), 0);
    for (int q = 0; q < NUM_QUEUES; q++) check("t6_cnt_full", qcnt(q), LL_DEPTH / NUM_QUEUES);
    enq(0, 0);
    tick();
    check("t6_ovf_set", int'(ovf_err), 1);
    check("t6_cnt_sat", qcnt(0), LL_DEPTH / NUM_QUEUES);
    tick(5);
    check("t6_ovf_sticky", int'(ovf_err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
